fwrisc_branch_decode: RTL and testbench
=======================================

FWRISC_BRANCH_DECODE -- requirements
Module: fwrisc_branch_decode

Interface
REQ-001 SHALL have ports: clock  input  1  clock; reset  input  1  synchronous, active-high reset.
REQ-002 SHALL have ports: fetch_valid  input  1  fetch presents instr; instr  input  32  instruction word; instr_c  input  1  instr[15:0] is a compressed instruction.
REQ-003 SHALL have port: decode_ready  output  1  one-cycle pulse; fetch may retire the current instr.
REQ-004 SHALL have ports: op_valid  output  1  decoded branch available; exec_ready  input  1  execute accepts op.
REQ-005 SHALL have ports:
- op_cond  output  3  funct3 (0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU);
- op_rs1  output  5;
- op_rs2  output  5;
- op_imm  output  32  sign-extended branch offset;
- op_illegal  output  1  not a legal branch.

Function
REQ-006 SHALL implement FSM states IDLE, VALID, DONE.
REQ-007 IDLE: when fetch_valid=1, SHALL register all op_* fields from instr and instr_c, set op_valid<=1, and go to VALID.
REQ-008 IDLE with fetch_valid=0 SHALL hold all outputs.
REQ-009 VALID: op_valid=1 and op_* fields SHALL stay stable until a cycle with exec_ready=1. On that cycle the block SHALL set op_valid<=0, decode_ready<=1, and go to DONE.
REQ-010 DONE: SHALL set decode_ready<=0, go to IDLE, and ignore fetch_valid for that cycle, so the retiring instr is never accepted twice.
REQ-011 All outputs SHALL be registered. Timing:
- fetch_valid sampled high at edge k gives op_valid=1 from cycle k+1.
- With exec_ready held at 1, decode_ready=1 in cycle k+2.
- The next accept is no earlier than edge k+3.
REQ-012 32-bit decode:
- op_rs1=instr[19:15], op_rs2=instr[24:20], op_cond=instr[14:12].
- op_imm = {20 copies of instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-013 op_illegal=1 when instr[6:0]!=7'b1100011 or instr[14:12] is 2 or 3. The block SHALL still extract fields, assert op_valid, and complete the handshake normally.
REQ-014 decode_ready SHALL never be high in two consecutive cycles, and SHALL never be high while op_valid=1 is being newly asserted.
REQ-015 exec_ready while the FSM is in IDLE or DONE SHALL be ignored.

Reset
REQ-016 While reset=1 the block SHALL go to state IDLE and drive:
- op_valid=0, decode_ready=0, op_illegal=0;
- op_cond=0, op_rs1=0, op_rs2=0, op_imm=0.
REQ-017 Reset asserted in VALID or DONE SHALL abort the op with no decode_ready pulse. The first accept is possible at the first edge after reset deasserts.

Configuration
REQ-018 Macro FWRISC_RVC_BRANCH_EN defined: when instr_c=1, the block SHALL decode instr[15:0] as follows.
- C.BEQZ (instr[15:13]=110, instr[1:0]=01): op_cond=0.
- C.BNEZ (instr[15:13]=111, instr[1:0]=01): op_cond=1.
- op_rs1 = 8 + instr[9:7]; op_rs2=0.
- op_imm = sign-extend bit 8 of {instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 0}.
- Any other 16-bit encoding SHALL give op_illegal=1.
REQ-019 Macro undefined: instr_c=1 SHALL always give op_illegal=1 with op_cond, op_rs1, op_rs2 and op_imm all 0. The compressed-decode logic SHALL be absent.

Verification
REQ-020 instr=0x00208463 (BEQ x1,x2,+8), instr_c=0, exec_ready=1 gives:
- op_cond=0, op_rs1=1, op_rs2=2, op_imm=0x00000008, op_illegal=0;
- op_valid one cycle after accept; decode_ready exactly 1 cycle wide, one cycle later.
REQ-021 instr=0xFE41FEE3 (BGEU x3,x4,-4) gives op_cond=7, op_rs1=3, op_rs2=4, op_imm=0xFFFFFFFC, op_illegal=0.
REQ-022 instr=0x00202063 (funct3=2) gives op_illegal=1; op_valid and the decode_ready pulse still occur.
REQ-023 Backpressure: exec_ready=0 for 5 cycles after op_valid rises gives:
- op_valid and fields stable, decode_ready=0, for those 5 cycles;
- exec_ready=1 on cycle 6 gives a decode_ready pulse in cycle 7 and op_valid=0 in cycle 7.
REQ-024 Reset for 1 cycle while in VALID gives all outputs 0 on the following cycle with no decode_ready pulse. A subsequent fetch of 0x00208463 decodes per REQ-020.
REQ-025 instr_c=1, instr=0x0000C001:
- with FWRISC_RVC_BRANCH_EN: op_cond=0, op_rs1=8, op_rs2=0, op_imm=0, op_illegal=0;
- without it: op_illegal=1.

Source files
------------

// File: rtl/fwrisc_branch_decode.sv
// Registered RISC-V conditional-branch decoder with a fetch/execute handshake.
// Define FWRISC_RVC_BRANCH_EN to also decode C.BEQZ / C.BNEZ when instr_c=1.
module fwrisc_branch_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] instr,
    input  logic        instr_c,
    output logic        decode_ready,
    output logic        op_valid,
    input  logic        exec_ready,
    output logic [2:0]  op_cond,
    output logic [4:0]  op_rs1,
    output logic [4:0]  op_rs2,
    output logic [31:0] op_imm,
    output logic        op_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        op_valid_q, op_valid_d;
    logic        decode_ready_q, decode_ready_d;
    logic [2:0]  op_cond_q, op_cond_d;
    logic [4:0]  op_rs1_q, op_rs1_d;
    logic [4:0]  op_rs2_q, op_rs2_d;
    logic [31:0] op_imm_q, op_imm_d;
    logic        op_illegal_q, op_illegal_d;

    logic [2:0]  dec_cond;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    // Field extraction from the current fetch word; only captured on accept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dec_cond    = 3'd0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        dec_imm     = 32'd0;
        dec_illegal = 1'b1;
        if (!instr_c) begin
            dec_cond    = instr[14:12];
            dec_rs1     = instr[19:15];
            dec_rs2     = instr[24:20];
            dec_imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            dec_illegal = (instr[6:0] != 7'b1100011) || (instr[14:13] == 2'b01);
        end
`ifdef FWRISC_RVC_BRANCH_EN
        else if (instr[1:0] == 2'b01 && instr[15:14] == 2'b11) begin
            // C.BEQZ / C.BNEZ compare rs1' against x0; funct3 bit 13 selects BNE.
            dec_cond    = {2'b00, instr[13]};
            dec_rs1     = {2'b01, instr[9:7]};
            dec_rs2     = 5'd0;
            dec_imm     = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
            dec_illegal = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        op_valid_d     = op_valid_q;
        decode_ready_d = decode_ready_q;
        op_cond_d      = op_cond_q;
        op_rs1_d       = op_rs1_q;
        op_rs2_d       = op_rs2_q;
        op_imm_d       = op_imm_q;
        op_illegal_d   = op_illegal_q;
        case (state_q)
            IDLE: begin
                if (fetch_valid) begin
                    op_cond_d    = dec_cond;
                    op_rs1_d     = dec_rs1;
                    op_rs2_d     = dec_rs2;
                    op_imm_d     = dec_imm;
                    op_illegal_d = dec_illegal;
                    op_valid_d   = 1'b1;
                    state_d      = VALID;
                end
            end
            VALID: begin
                if (exec_ready) begin
                    op_valid_d     = 1'b0;
                    decode_ready_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                // fetch_valid still shows the retiring word here, so it is not sampled.
                decode_ready_d = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q        <= IDLE;
            op_valid_q     <= 1'b0;
            decode_ready_q <= 1'b0;
            op_cond_q      <= 3'd0;
            op_rs1_q       <= 5'd0;
            op_rs2_q       <= 5'd0;
            op_imm_q       <= 32'd0;
            op_illegal_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_valid_q     <= op_valid_d;
            decode_ready_q <= decode_ready_d;
            op_cond_q      <= op_cond_d;
            op_rs1_q       <= op_rs1_d;
            op_rs2_q       <= op_rs2_d;
            op_imm_q       <= op_imm_d;
            op_illegal_q   <= op_illegal_d;
        end
    end

    assign op_valid     = op_valid_q;
    assign decode_ready = decode_ready_q;
    assign op_cond      = op_cond_q;
    assign op_rs1       = op_rs1_q;
    assign op_rs2       = op_rs2_q;
    assign op_imm       = op_imm_q;
    assign op_illegal   = op_illegal_q;

endmodule

// File: tb/tb_fwrisc_branch_decode.sv
// Scoreboard bench for fwrisc_branch_decode: a driver pushes reference-model results,
// a free-running monitor pops them when op_valid rises and checks handshake timing.
module tb_fwrisc_branch_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_c = 1'b0;
    logic        exec_ready = 1'b0;
    logic        decode_ready;
    logic        op_valid;
    logic [2:0]  op_cond;
    logic [4:0]  op_rs1;
    logic [4:0]  op_rs2;
    logic [31:0] op_imm;
    logic        op_illegal;

    fwrisc_branch_decode dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .instr        (instr),
        .instr_c      (instr_c),
        .decode_ready (decode_ready),
        .op_valid     (op_valid),
        .exec_ready   (exec_ready),
        .op_cond      (op_cond),
        .op_rs1       (op_rs1),
        .op_rs2       (op_rs2),
        .op_imm       (op_imm),
        .op_illegal   (op_illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  cond;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } op_t;

    op_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: branch offsets built arithmetically from the encoding's bit weights.
    function automatic op_t model(input logic [31:0] w, input logic c);
        op_t m;
        int  off;
        m = '{cond: 3'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, illegal: 1'b1};
        if (!c) begin
            m.cond = w[14:12];
            m.rs1  = w[19:15];
            m.rs2  = w[24:20];
            off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                + int'(w[11:8]) * 2;
            m.imm = off;
            m.illegal = !(w[6:0] == 7'h63 && w[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
        end
`ifdef FWRISC_RVC_BRANCH_EN
        else if (w[1:0] == 2'b01 && (w[15:13] == 3'd6 || w[15:13] == 3'd7)) begin
            m.cond = (w[15:13] == 3'd6) ? 3'd0 : 3'd1;
            m.rs1  = 5'(8 + int'(w[9:7]));
            m.rs2  = 5'd0;
            off = (w[12] ? -256 : 0) + int'(w[6:5]) * 64 + int'(w[2]) * 32
                + int'(w[11:10]) * 8 + int'(w[4:3]) * 2;
            m.imm = off;
            m.illegal = 1'b0;
        end
`endif
        return m;
    endfunction

    // One fetch: present, expect op_valid next edge, stall exec_ready, expect retire.
    task automatic run_op(input logic [31:0] w, input logic c, input int stall);
        int n;
        @(negedge clock);
        reset       = 1'b0;
        fetch_valid = 1'b1;
        instr       = w;
        instr_c     = c;
        exec_ready  = 1'($urandom_range(0, 1));
        exp_q.push_back(model(w, c));
        @(posedge clock); #1;
        check("accept_latency", op_valid, 1'b1);
        n = 0;
        while (!decode_ready && n < 40) begin
            @(negedge clock);
            exec_ready = (n >= stall);
            @(posedge clock); #1;
            n++;
        end
        check("retire_latency", n, stall + 1);
        // Retiring word stays on the fetch port through the DONE cycle.
        @(negedge clock);
        exec_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycles(input int g);
        repeat (g) begin
            @(negedge clock);
            fetch_valid = 1'b0;
            instr       = $urandom;
            exec_ready  = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] w;
        int legal_f[6] = '{0, 1, 4, 5, 6, 7};
        w = $urandom;
        case (kind)
            0, 1: begin
                w[6:0]   = 7'h63;
                w[14:12] = 3'(legal_f[$urandom_range(0, 5)]);
            end
            2: begin
                w[6:0]   = 7'h63;
                w[14:13] = 2'b01;
            end
            4: begin
                w[1:0]   = 2'b01;
                w[15:14] = 2'b11;
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin : monitor
        logic prev_ov;
        op_t  prev;
        op_t  e;
        prev_ov = 1'b0;
        prev = '{cond: 3'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, illegal: 1'b0};
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                check("reset_op_valid", op_valid, 1'b0);
                check("reset_decode_ready", decode_ready, 1'b0);
                check("reset_fields", {op_cond, op_rs1, op_rs2, op_illegal}, 14'd0);
                check("reset_imm", op_imm, 32'd0);
            end else begin
                check("decode_ready", decode_ready, prev_ov && exec_ready);
                if (prev_ov)
                    check("op_valid_after_handshake", op_valid, !exec_ready);
                if (!prev_ov && op_valid) begin
                    check("pending_ops", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("op_cond", op_cond, e.cond);
                        check("op_rs1", op_rs1, e.rs1);
                        check("op_rs2", op_rs2, e.rs2);
                        check("op_imm", op_imm, e.imm);
                        check("op_illegal", op_illegal, e.illegal);
                    end
                end else begin
                    check("hold_fields", {op_cond, op_rs1, op_rs2, op_illegal},
                          {prev.cond, prev.rs1, prev.rs2, prev.illegal});
                    check("hold_imm", op_imm, prev.imm);
                end
            end
            prev_ov = op_valid;
            prev = '{cond: op_cond, rs1: op_rs1, rs2: op_rs2, imm: op_imm, illegal: op_illegal};
        end
    end

    initial begin : driver
        logic [31:0] w;
        logic        c;
        int          kind;
        repeat (3) @(negedge clock);

        run_op(32'h00208463, 1'b0, 0);
        check("beq_imm", op_imm, 32'h00000008);
        check("beq_regs", {op_rs1, op_rs2}, {5'd1, 5'd2});
        run_op(32'hFE41FEE3, 1'b0, 1);
        check("bgeu_cond", op_cond, 3'd7);
        check("bgeu_imm", op_imm, 32'hFFFFFFFC);
        run_op(32'h00202063, 1'b0, 2);
        check("funct3_2_illegal", op_illegal, 1'b1);
        run_op(32'h00208463, 1'b0, 5);
        run_op(32'h0000C001, 1'b1, 0);
`ifdef FWRISC_RVC_BRANCH_EN
        check("c_beqz_legal", op_illegal, 1'b0);
        check("c_beqz_rs1", op_rs1, 5'd8);
`else
        check("c_disabled_illegal", op_illegal, 1'b1);
        check("c_disabled_imm", op_imm, 32'd0);
`endif

        // Reset while an op is waiting in VALID: aborted, no retire pulse.
        idle_cycles(1);
        @(negedge clock);
        fetch_valid = 1'b1;
        instr       = 32'hFE41FEE3;
        instr_c     = 1'b0;
        exec_ready  = 1'b0;
        exp_q.push_back(model(32'hFE41FEE3, 1'b0));
        @(posedge clock); #1;
        check("pre_reset_valid", op_valid, 1'b1);
        @(negedge clock);
        reset       = 1'b1;
        fetch_valid = 1'b0;
        @(posedge clock); #1;
        check("reset_abort_valid", op_valid, 1'b0);
        check("reset_abort_imm", op_imm, 32'd0);
        run_op(32'h00208463, 1'b0, 0);
        check("post_reset_imm", op_imm, 32'h00000008);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            c = (kind >= 4);
            w = rand_instr(kind);
            run_op(w, c, $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
